// File: rtl/fp32_pkg.sv
// Single-precision field widths, constants and shared FSM / operand-class types
// for the multi-cycle FP32 divider.
package fp32_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned MANT_W   = FRAC_W + 1;
  localparam int unsigned QUO_W    = 26;
  localparam int unsigned REM_W    = 26;
  localparam int unsigned EXPI_W   = 10;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] POS_INF  = 32'h7F800000;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_e;
  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
  } fp_flags_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational operand classifier: denormals count as zero, exp==255 splits
// into inf / NaN on the fraction.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] op_i,
  output fp_class_e   cls_c
);

  fp32_t op;
  assign op = fp32_t'(op_i);

  always_comb begin
    cls_c = NORMAL;
    if (op.exp == '0) begin
      cls_c = ZERO;
    end else if (op.exp == '1) begin
      cls_c = (op.frac == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/ieee754_divider.sv
// Multi-cycle FP32 divider a / b with a restoring mantissa divider retiring
// BITS_PER_CYCLE quotient bits per clock. FPDIV_ROUND_RNE_EN selects RNE, else truncation.
module ieee754_divider
  import fp32_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero,
  output logic        invalid
);

  localparam int unsigned STEPS = QUO_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = 5;

  state_e                   state_q, state_d;
  logic [REM_W-1:0]         rem_q, rem_d, rem_step;
  logic [MANT_W-1:0]        dvs_q, dvs_d;
  logic [QUO_W-1:0]         quo_q, quo_d, quo_step;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [EXPI_W-1:0] exp_q, exp_d, norm_exp, round_exp;
  logic                     sign_q, sign_d;
  logic                     special_q, special_d;
  logic [31:0]              spec_res_q, spec_res_d;
  fp_flags_t                spec_flg_q, spec_flg_d;
  logic [31:0]              result_q, result_d;
  fp_flags_t                flags_q, flags_d;
  logic                     busy_q, busy_d, done_q, done_d;

  fp32_t       op_a, op_b;
  fp_class_e   cls_a, cls_b;
  logic        spec_hit, spec_sign;
  logic [31:0] spec_res;
  fp_flags_t   spec_flg;
  logic [FRAC_W-1:0] norm_frac, round_frac;
  logic [31:0] norm_res;
  fp_flags_t   norm_flg;

  assign op_a = fp32_t'(a);
  assign op_b = fp32_t'(b);

  fp32_classify u_cls_a (.op_i(a), .cls_c(cls_a));
  fp32_classify u_cls_b (.op_i(b), .cls_c(cls_b));

  // Special operands resolve at acceptance and skip the iterative divide.
  always_comb begin
    spec_hit  = 1'b1;
    spec_sign = op_a.sign ^ op_b.sign;
    spec_res  = QNAN;
    spec_flg  = '0;
    if (cls_a == NAN || cls_b == NAN || (cls_a == ZERO && cls_b == ZERO) ||
        (cls_a == INF && cls_b == INF)) begin
      spec_flg.invalid = 1'b1;
    end else if (cls_a == INF) begin
      spec_res = {spec_sign, POS_INF[30:0]};
    end else if (cls_b == ZERO) begin
      spec_res             = {spec_sign, POS_INF[30:0]};
      spec_flg.div_by_zero = 1'b1;
    end else if (cls_a == ZERO || cls_b == INF) begin
      spec_res = {spec_sign, 31'h0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // BITS_PER_CYCLE restoring steps chained within one clock.
  always_comb begin
    rem_step = rem_q;
    quo_step = quo_q;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (rem_step >= REM_W'(dvs_q)) begin
        rem_step = rem_step - REM_W'(dvs_q);
        quo_step = {quo_step[QUO_W-2:0], 1'b1};
      end else begin
        quo_step = {quo_step[QUO_W-2:0], 1'b0};
      end
      rem_step = rem_step << 1;
    end
  end

`ifdef FPDIV_ROUND_RNE_EN
  logic              guard, sticky;
  logic [FRAC_W:0]   frac_inc;
`else
  logic              unused_quo_lsb;
  assign unused_quo_lsb = quo_q[0];
`endif

  // Normalise the quotient (hidden bit is q[25] or q[24]), round, range-check.
  always_comb begin
    norm_frac = quo_q[QUO_W-1] ? quo_q[QUO_W-2:2] : quo_q[QUO_W-3:1];
    norm_exp  = quo_q[QUO_W-1] ? exp_q : exp_q - EXPI_W'(1);
`ifdef FPDIV_ROUND_RNE_EN
    guard      = quo_q[QUO_W-1] ? quo_q[1] : quo_q[0];
    sticky     = (rem_q != '0) | (quo_q[QUO_W-1] & quo_q[0]);
    frac_inc   = {1'b0, norm_frac} + (FRAC_W + 1)'(guard & (sticky | norm_frac[0]));
    round_frac = frac_inc[FRAC_W-1:0];
    round_exp  = norm_exp + EXPI_W'(frac_inc[FRAC_W]);
`else
    round_frac = norm_frac;
    round_exp  = norm_exp;
`endif
    norm_flg = '0;
    if (round_exp >= $signed(EXPI_W'(EXP_MAX))) begin
      norm_res          = {sign_q, POS_INF[30:0]};
      norm_flg.overflow = 1'b1;
    end else if (round_exp <= $signed(EXPI_W'(0))) begin
      norm_res           = {sign_q, 31'h0};
      norm_flg.underflow = 1'b1;
    end else begin
      norm_res = {sign_q, round_exp[EXP_W-1:0], round_frac};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    spec_flg_d = spec_flg_q;
    result_d   = result_q;
    flags_d    = flags_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d    = spec_hit ? NORM : DIVIDE;
          rem_d      = REM_W'({1'b1, op_a.frac});
          dvs_d      = {1'b1, op_b.frac};
          quo_d      = '0;
          cnt_d      = '0;
          exp_d      = EXPI_W'(op_a.exp) - EXPI_W'(op_b.exp) + EXPI_W'(EXP_BIAS);
          sign_d     = op_a.sign ^ op_b.sign;
          special_d  = spec_hit;
          spec_res_d = spec_res;
          spec_flg_d = spec_flg;
          flags_d    = '0;
        end
      end
      DIVIDE: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) state_d = NORM;
      end
      NORM: begin
        state_d  = DONE;
        result_d = special_q ? spec_res_q : norm_res;
        flags_d  = special_q ? spec_flg_q : norm_flg;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DIVIDE) || (state_d == NORM);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      spec_flg_q <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      spec_flg_q <= spec_flg_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign overflow    = flags_q.overflow;
  assign underflow   = flags_q.underflow;
  assign div_by_zero = flags_q.div_by_zero;
  assign invalid     = flags_q.invalid;

endmodule

// File: tb/tb_ieee754_divider.sv
// Directed bench for ieee754_divider: one-bit and two-bit-per-cycle instances,
// an exact-arithmetic quotient model feeding a scoreboard, plus literal checks.
module tb_ieee754_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start1, start2;
  logic [31:0] a1, b1, a2, b2;
  logic        busy1, done1, ovf1, unf1, dbz1, inv1;
  logic        busy2, done2, ovf2, unf2, dbz2, inv2;
  logic [31:0] res1, res2;

  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] sb1[$];
  logic [35:0] sb2[$];

`ifdef FPDIV_ROUND_RNE_EN
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
`endif

  ieee754_divider #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(res1), .overflow(ovf1),
    .underflow(unf1), .div_by_zero(dbz1), .invalid(inv1)
  );

  ieee754_divider #(.BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(res2), .overflow(ovf2),
    .underflow(unf2), .div_by_zero(dbz2), .invalid(inv2)
  );

  // Expected {invalid, div_by_zero, overflow, underflow, result} from exact integer division.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e;
    bit xn, yn, xi, yi, xz, yz, s, g, st;
    longint unsigned ma, mb, num, q, r, m;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);
    yz = (ey == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    if (xn || yn || (xz && yz) || (xi && yi)) return {4'b1000, 32'h7FC00000};
    if (xi) return {4'b0000, s, 31'h7F800000};
    if (yz) return {4'b0100, s, 31'h7F800000};
    if (xz || yi) return {4'b0000, s, 31'h0};
    ma  = 64'h800000 + longint'(x[22:0]);
    mb  = 64'h800000 + longint'(y[22:0]);
    num = ma << 25;
    q   = num / mb;
    r   = num % mb;
    e   = ex - ey + 127;
    if (q >= 64'h2000000) begin
      m = q >> 2; g = q[1]; st = q[0] || (r != 0);
    end else begin
      m = q >> 1; g = q[0]; st = (r != 0); e = e - 1;
    end
`ifdef FPDIV_ROUND_RNE_EN
    if (g && (st || m[0])) m = m + 1;
    if (m >= 64'h1000000) begin
      m = 64'h800000; e = e + 1;
    end
`endif
    if (e >= 255) return {4'b0010, s, 31'h7F800000};
    if (e <= 0)   return {4'b0001, s, 31'h0};
    return {4'b0000, s, 8'(e), 23'(m)};
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %010h expected %010h", name, act, exp);
    end
  endtask

  task automatic issue(input int sel, input logic [31:0] x, input logic [31:0] y, input bit push);
    @(negedge clk);
    if (sel == 1) begin
      a1 = x; b1 = y; start1 = 1'b1;
      if (push) sb1.push_back(model(x, y));
    end else begin
      a2 = x; b2 = y; start2 = 1'b1;
      if (push) sb2.push_back(model(x, y));
    end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Returns clocks from the start-sampling edge to the edge raising done (inclusive).
  task automatic wait_done(input int sel, input int max, output int lat);
    int cyc;
    cyc = 0;
    while (((sel == 1) ? done1 : done2) !== 1'b1 && cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    lat = cyc + 1;
  endtask

  // Scoreboard compare: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done1 === 1'b1) begin
      n_cmp++;
      if (sb1.size() == 0) begin
        n_err++;
        $display("FAIL sb1_unexpected_done: result %08h, no operation outstanding", res1);
      end else begin
        logic [35:0] e1;
        e1 = sb1.pop_front();
        if ({inv1, dbz1, ovf1, unf1, res1} !== e1) begin
          n_err++;
          $display("FAIL sb1_result: got %09h expected %09h", {inv1, dbz1, ovf1, unf1, res1}, e1);
        end
      end
    end
    if (rst_n === 1'b1 && done2 === 1'b1) begin
      n_cmp++;
      if (sb2.size() == 0) begin
        n_err++;
        $display("FAIL sb2_unexpected_done: result %08h, no operation outstanding", res2);
      end else begin
        logic [35:0] e2;
        e2 = sb2.pop_front();
        if ({inv2, dbz2, ovf2, unf2, res2} !== e2) begin
          n_err++;
          $display("FAIL sb2_result: got %09h expected %09h", {inv2, dbz2, ovf2, unf2, res2}, e2);
        end
      end
    end
  end

  logic [31:0] va [8] = '{32'hC0A00000, 32'h3F800000, 32'h7FC00000, 32'h7F800000,
                          32'h00000000, 32'h3FFFFFFF, 32'h40490FDB, 32'h007FFFFF};
  logic [31:0] vb [8] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                          32'h40A00000, 32'h3F800001, 32'hC02DF854, 32'h3F800000};

  initial begin
    int lat, lat_b;
    int dones;
    start1 = 1'b0; start2 = 1'b0;
    a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dut1", {2'b0, busy1, done1, inv1, dbz1, ovf1, unf1, res1}, 40'h0);
    chk("reset_dut2", {2'b0, busy2, done2, inv2, dbz2, ovf2, unf2, res2}, 40'h0);
    @(negedge clk) rst_n = 1'b1;

    // Hand-computed pins of the model itself.
    chk("model_6_2",   40'(model(32'h40C00000, 32'h40000000)), 40'h0_40400000);
    chk("model_1_3",   40'(model(32'h3F800000, 32'h40400000)), {8'h0, ONE_THIRD});
    chk("model_1_0",   40'(model(32'h3F800000, 32'h00000000)), 40'h4_7F800000);
    chk("model_ovf",   40'(model(32'h7F000000, 32'h3E800000)), 40'h2_7F800000);
    chk("model_unf",   40'(model(32'h00800000, 32'h40000000)), 40'h1_00000000);

    // 6.0 / 2.0: latency and value.
    issue(1, 32'h40C00000, 32'h40000000, 1'b1);
    chk("busy_during_div", 40'(busy1), 40'h1);
    wait_done(1, 60, lat);
    chk("lat_6_2", 40'(lat), 40'd28);
    chk("res_6_2", {4'h0, inv1, dbz1, ovf1, unf1, res1}, 40'h0_40400000);
    @(posedge clk); #1;
    chk("done_width", 40'(done1), 40'h0);

    // 1.0 / 3.0 rounding.
    issue(1, 32'h3F800000, 32'h40400000, 1'b1);
    wait_done(1, 60, lat);
    chk("res_1_3", {4'h0, inv1, dbz1, ovf1, unf1, res1}, {8'h0, ONE_THIRD});

    // Specials: 2-clock latency, flags hold, flags clear on next accepted start.
    issue(1, 32'h3F800000, 32'h00000000, 1'b1);
    wait_done(1, 10, lat);
    chk("lat_1_0", 40'(lat), 40'd2);
    chk("res_1_0", {4'h0, inv1, dbz1, ovf1, unf1, res1}, 40'h4_7F800000);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_1_0", {4'h0, inv1, dbz1, ovf1, unf1, res1}, 40'h4_7F800000);
    issue(1, 32'h00000000, 32'h00000000, 1'b1);
    chk("flags_clear", {4'h0, inv1, dbz1, ovf1, unf1, res1}, 40'h0_7F800000);
    wait_done(1, 10, lat);
    chk("lat_0_0", 40'(lat), 40'd2);
    chk("res_0_0", {4'h0, inv1, dbz1, ovf1, unf1, res1}, 40'h8_7FC00000);
    issue(1, 32'hBF800000, 32'h7F800000, 1'b1);
    wait_done(1, 10, lat);
    chk("lat_m1_inf", 40'(lat), 40'd2);
    chk("res_m1_inf", {4'h0, inv1, dbz1, ovf1, unf1, res1}, 40'h0_80000000);

    // Range limits.
    issue(1, 32'h7F000000, 32'h3E800000, 1'b1);
    wait_done(1, 60, lat);
    chk("res_ovf", {4'h0, inv1, dbz1, ovf1, unf1, res1}, 40'h2_7F800000);
    issue(1, 32'h00800000, 32'h40000000, 1'b1);
    wait_done(1, 60, lat);
    chk("res_unf", {4'h0, inv1, dbz1, ovf1, unf1, res1}, 40'h1_00000000);

    // Further patterns checked by the scoreboard only.
    for (int i = 0; i < 8; i++) begin
      issue(1, va[i], vb[i], 1'b1);
      wait_done(1, 60, lat);
    end

    // start while busy is ignored.
    issue(1, 32'h40C00000, 32'h40000000, 1'b1);
    repeat (3) @(posedge clk);
    issue(1, 32'h3F800000, 32'h40400000, 1'b0);
    chk("busy_at_ignore", 40'(busy1), 40'h1);
    wait_done(1, 60, lat);
    chk("lat_ignore", 40'(lat + 4), 40'd28);
    chk("res_ignore", {4'h0, inv1, dbz1, ovf1, unf1, res1}, 40'h0_40400000);
    repeat (30) @(posedge clk);

    // Reset mid-operation.
    issue(1, 32'h3F800000, 32'h40400000, 1'b0);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid", {2'b0, busy1, done1, inv1, dbz1, ovf1, unf1, res1}, 40'h0);
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) dones++;
    end
    chk("no_done_after_reset", 40'(dones), 40'h0);
    issue(1, 32'h3F800000, 32'h00000000, 1'b1);
    wait_done(1, 10, lat);
    chk("idle_after_reset", 40'(lat), 40'd2);

    // Back-to-back on the two-bits-per-cycle instance.
    issue(2, 32'h40C00000, 32'h40000000, 1'b1);
    wait_done(2, 40, lat);
    chk("lat2_first", 40'(lat), 40'd15);
    chk("res2_first", {4'h0, inv2, dbz2, ovf2, unf2, res2}, 40'h0_40400000);
    issue(2, 32'h3F800000, 32'h3F000000, 1'b1);
    wait_done(2, 40, lat_b);
    chk("done_spacing", 40'(lat_b), 40'd15);
    chk("res2_second", {4'h0, inv2, dbz2, ovf2, unf2, res2}, 40'h0_40000000);
    issue(2, 32'h3F800000, 32'h40400000, 1'b1);
    wait_done(2, 40, lat);

    repeat (4) @(posedge clk);
    chk("sb1_drained", 40'(sb1.size()), 40'h0);
    chk("sb2_drained", 40'(sb2.size()), 40'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
